// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared defaults, limits and stage-operation encoding for pipe_chain
package pipe_pkg;

  localparam int PIPE_WIDTH_DEF = 32;
  localparam int PIPE_DEPTH_DEF = 5;
  localparam int PIPE_WIDTH_MAX = 64;
  localparam int PIPE_DEPTH_MAX = 16;
  localparam int PIPE_CNT_W     = 32;

  typedef enum logic [1:0] {
    ST_ADVANCE = 2'd0,
    ST_BUBBLE  = 2'd1,
    ST_HOLD    = 2'd2,
    ST_FLUSH   = 2'd3
  } stage_op_e;

  // Flush beats hold, hold beats bubble, bubble beats advance.
  function automatic stage_op_e stage_op(input logic flush, input logic hold, input logic bubble);
    stage_op_e op;
    op = ST_ADVANCE;
    if (flush) begin
      op = ST_FLUSH;
    end else if (hold) begin
      op = ST_HOLD;
    end else if (bubble) begin
      op = ST_BUBBLE;
    end
    return op;
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - one pipeline stage: flush/hold/bubble/advance mux plus valid and data flops
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             hold_i,
  input  logic             bubble_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  stage_op_e        op;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    op      = stage_op(flush_i, hold_i, bubble_i);
    case (op)
      ST_FLUSH, ST_BUBBLE: begin
        valid_d = 1'b0;
        data_d  = '0;
      end
      ST_HOLD: begin
        valid_d = valid_q;
        data_d  = data_q;
      end
      default: begin
        // Payload is zeroed on load so an invalid stage never shows stale data.
        valid_d = valid_i;
        data_d  = valid_i ? data_i : '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_chain.sv
// rtl/pipe_chain.sv - DEPTH-stage stallable/flushable pipeline built from pipe_stage_reg
// Optional PIPE_PERF_CNT_EN adds saturating stall_cnt / bubble_cnt outputs.
module pipe_chain
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH_DEF,
  parameter int DEPTH = PIPE_DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  input  logic [DEPTH-1:0]       stall,
  input  logic [DEPTH-1:0]       flush,
  output logic [DEPTH-1:0]       stage_valid,
  output logic [DEPTH*WIDTH-1:0] stage_data,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [PIPE_CNT_W-1:0]  stall_cnt,
  output logic [PIPE_CNT_W-1:0]  bubble_cnt
`endif
);

  logic [DEPTH-1:0] hold;
  logic [DEPTH-1:0] bubble;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             src_valid;
    logic [WIDTH-1:0] src_data;

    // A stall anywhere downstream freezes this stage too.
    assign hold[i] = |stall[DEPTH-1:i];

    if (i == 0) begin : g_head
      assign src_valid = in_valid;
      assign src_data  = in_data;
      assign bubble[i] = 1'b0;
    end else begin : g_body
      assign src_valid = stage_valid[i-1];
      assign src_data  = stage_data[(i-1)*WIDTH +: WIDTH];
      assign bubble[i] = stall[i-1] & ~hold[i];
    end

    pipe_stage_reg #(.WIDTH(WIDTH)) u_stage (
      .clk      (clk),
      .rst_n    (rst),
      .flush_i  (flush[i]),
      .hold_i   (hold[i]),
      .bubble_i (bubble[i]),
      .valid_i  (src_valid),
      .data_i   (src_data),
      .valid_o  (stage_valid[i]),
      .data_o   (stage_data[i*WIDTH +: WIDTH])
    );
  end

  assign in_ready  = ~hold[0];
  assign out_valid = stage_valid[DEPTH-1];
  assign out_data  = stage_data[(DEPTH-1)*WIDTH +: WIDTH];

`ifdef PIPE_PERF_CNT_EN
  logic [PIPE_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PIPE_CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [PIPE_CNT_W-1:0] bubble_inc;
  logic [PIPE_CNT_W:0]   bubble_sum;
  logic [DEPTH-1:0]      bubble_taken;

  // A flushed stage is not counted as a bubble even if the bubble path was selectable.
  assign bubble_taken = bubble & ~flush;
  assign bubble_inc   = PIPE_CNT_W'($countones(bubble_taken));

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_sum   = {1'b0, bubble_cnt_q} + {1'b0, bubble_inc};
    bubble_cnt_d = bubble_sum[PIPE_CNT_W] ? '1 : bubble_sum[PIPE_CNT_W-1:0];
    if (hold[0] && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: doc/pipe_chain.md
PIPE_CHAIN -- requirements
Module: pipe_chain

Interface
REQ-001 Parameter WIDTH, default 32: payload width of every stage, legal range 1..64.
REQ-002 Parameter DEPTH, default 5: number of pipeline stages, legal range 1..16.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1: reset, asynchronous and active-low.
REQ-005 Port in_valid  input  1: stage-0 input carries a valid item.
REQ-006 Port in_data  input  WIDTH: stage-0 input payload.
REQ-007 Port in_ready  output  1: stage 0 accepts input this cycle; combinational, equal to NOT h[0].
REQ-008 Port stall  input  DEPTH: stall[i] freezes stage i and every younger stage (index < i).
REQ-009 Port flush  input  DEPTH: flush[i] invalidates stage i at the next edge.
REQ-010 Port stage_valid  output  DEPTH: registered valid bit of each stage.
REQ-011 Port stage_data  output  DEPTH*WIDTH: registered payloads, flattened; stage i occupies bits [i*WIDTH +: WIDTH].
REQ-012 Port out_valid / out_data  output  1 / WIDTH: stage DEPTH-1 valid bit and payload.

Function
REQ-013 h[i] SHALL be the OR of stall[j] for j = i..DEPTH-1; this is the effective hold of stage i.
REQ-014 Per-stage update priority, highest first: flush[i], then h[i], then bubble, then advance.
- flush[i]: valid <= 0, data <= 0.
- h[i]: valid and data held.
- Bubble (i>0, stall[i-1]=1, h[i]=0): valid <= 0, data <= 0.
- Advance: stage i loads stage i-1; stage 0 loads in_valid/in_data.
REQ-015 Stage 0 SHALL load in_valid only when in_ready=1; when h[0]=1 the input is not consumed and the source holds it.
REQ-016 Latency SHALL be DEPTH cycles from input acceptance to out_valid when no stall or flush occurs.
REQ-017 Flush SHALL override stall on the same stage in the same cycle; a flushed stage still holding under stall becomes an invalid, held bubble.
REQ-018 Out_valid SHALL not be gated by any downstream ready; stall[DEPTH-1] is the only way to hold the output.
REQ-019 When DEPTH=1, stall[0] holds the single stage and no bubble path exists.
REQ-020 Data of invalid stages SHALL always read 0.

Reset
REQ-021 While rst=0, all stage_valid and stage_data bits SHALL clear to 0 asynchronously, and the performance counters SHALL clear to 0.
REQ-022 Reset deassertion mid-stream SHALL discard all in-flight items; the first edge after release behaves as from the empty state.

Configuration
REQ-023 With PIPE_PERF_CNT_EN defined, the block SHALL add output ports stall_cnt (32) and bubble_cnt (32).
- stall_cnt increments each cycle that h[0]=1.
- bubble_cnt increments by the number of bubbles inserted that cycle.
- Both counters saturate at all-ones.
REQ-024 Without PIPE_PERF_CNT_EN, those ports and counters SHALL be absent, and function is otherwise identical.

Structure
REQ-025 Package pipe_pkg SHALL hold the WIDTH/DEPTH defaults, their legal maxima, and the counter width constant PIPE_CNT_W=32.
REQ-026 Sub-module pipe_stage_reg SHALL implement one stage (flush/hold/bubble/advance mux plus valid and data flops); pipe_chain instantiates DEPTH copies and computes h[] and in_ready.

Verification
REQ-027 The bench SHALL cover these directed scenarios, each with the stated required response:
- DEPTH=5: inject 0xA1..0xA5 on consecutive cycles, no stall -> out_data shows 0xA1 five cycles after the first accept, then 0xA2..0xA5 back-to-back.
- Stall[2] held 2 cycles with all stages full -> stages 0..2 hold; stage 3 receives two bubbles; in_ready=0 for both cycles; order preserved at output.
- Flush[0] and flush[1] together with stall[1] -> stages 0..1 become valid=0, data=0; stage 2 receives a bubble; stages 3..4 advance.
- rst pulled low asynchronously between edges with the pipe full -> all stage_valid=0 immediately; after release, a new item 0x55 exits in exactly 5 cycles.
- DEPTH=1, WIDTH=8: stall[0]=1 with in_valid=1 -> stage holds its prior value and in_ready=0.
- PIPE_PERF_CNT_EN: 3 cycles of stall[4] followed by 1 cycle of stall[1] -> stall_cnt=4, bubble_cnt=1 (from the stall[1] cycle only).
